// File: rtl/dsec_pkg.sv
// dsec_pkg
//   Shared definitions for the DSEC input front-end: data/key widths,
//   key count, controller state encoding and the packed key-array type.
package dsec_pkg;

    localparam int DATA_W   = 64;
    localparam int NUM_KEYS = 3;
    localparam int KIDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // no usable keys
        ST_KEYLOAD = 2'd1,  // partial key set
        ST_READY   = 2'd2,  // keys valid, waiting for data
        ST_BUSY    = 2'd3   // core working on a word
    } dsec_state_e;

    typedef logic [NUM_KEYS-1:0][DATA_W-1:0] key_arr_t;

endpackage

// File: rtl/dsec_key_regs.sv
// dsec_key_regs
//   Key register file for the triple-DES keys. Words are written at an
//   internal index that advances on each write; the write that fills the
//   last slot sets keys_valid and rewinds the index.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   wr_i          - store data_i at the current index
//   start_i       - this write begins a new set: clear keys_valid, index 0
//   abort_i       - drop a partial set (index back to 0)
//   data_i        - key word
//   keys_o        - all key registers
//   keys_valid_o  - complete set loaded
//   last_o        - this cycle's write completes the set
module dsec_key_regs
    import dsec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] data_i,
    output key_arr_t          keys_o,
    output logic              keys_valid_o,
    output logic              last_o
);

    localparam logic [KIDX_W-1:0] LAST_IDX = KIDX_W'(NUM_KEYS - 1);

    key_arr_t          keys_q;
    logic              valid_q;
    logic [KIDX_W-1:0] idx_q;
    logic [KIDX_W-1:0] wr_idx;

    // A new set always starts at slot 0 regardless of a stale index.
    assign wr_idx = start_i ? '0 : idx_q;
    assign last_o = wr_i && (wr_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            keys_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            if (start_i) valid_q <= 1'b0;
            if (wr_i) begin
                keys_q[wr_idx] <= data_i;
                if (wr_idx == LAST_IDX) begin
                    idx_q   <= '0;
                    valid_q <= 1'b1;
                end else begin
                    idx_q <= wr_idx + KIDX_W'(1);
                end
            end else if (abort_i) begin
                idx_q <= '0;
            end
        end
    end

    assign keys_o       = keys_q;
    assign keys_valid_o = valid_q;

endmodule

// File: rtl/dsec_in_ctrl.sv
// dsec_in_ctrl
//   Input front-end of the DSEC data path. Loads the three 3DES keys from
//   the host (key_config/in_valid protocol), forwards plaintext words to the
//   crypto core with a start/done handshake, and flags protocol errors and
//   core timeouts on a sticky error output.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   data_in         - host key or data word
//   key_config      - high: accepted words are key words
//   in_valid        - host offers a word this cycle
//   rdy             - registered; block can accept a word
//   error           - sticky protocol / timeout error
//   key1..key3      - key registers to the core
//   keys_valid      - complete key set loaded
//   core_data       - word presented to the core, stable while busy
//   core_start      - one-cycle pulse, core_data valid
//   core_done       - one-cycle pulse from the core
module dsec_in_ctrl
    import dsec_pkg::*;
#(
    parameter int DONE_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              key_config,
    input  logic              in_valid,
    output logic              rdy,
    output logic              error,
    output logic [DATA_W-1:0] key1,
    output logic [DATA_W-1:0] key2,
    output logic [DATA_W-1:0] key3,
    output logic              keys_valid,
    output logic [DATA_W-1:0] core_data,
    output logic              core_start,
    input  logic              core_done
);

    localparam int             WD_W    = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(DONE_TIMEOUT - 1);

    dsec_state_e       state_q, state_d;
    logic              rdy_q, rdy_d;
    logic              error_q;
    logic              start_q;
    logic [DATA_W-1:0] cdata_q;
    logic [WD_W-1:0]   wd_q;

    logic     accept;
    logic     key_wr, key_start, key_abort, key_last;
    logic     issue, err_set, wd_expired;
    key_arr_t keys;

    assign accept = in_valid && rdy_q;

    // Watchdog fires on the last counted BUSY cycle unless done arrives
    // in that same cycle (done wins).
    assign wd_expired = (state_q == ST_BUSY) && !core_done && (wd_q == WD_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && key_config) state_d = ST_KEYLOAD;
            end
            ST_KEYLOAD: begin
                if (accept) begin
                    if (!key_config)  state_d = ST_IDLE;
                    else if (key_last) state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (accept) state_d = key_config ? ST_KEYLOAD : ST_BUSY;
            end
            ST_BUSY: begin
                if (core_done || wd_expired) state_d = ST_READY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- output / strobe decode ----------------
    always_comb begin
        key_wr    = 1'b0;
        key_start = 1'b0;
        key_abort = 1'b0;
        issue     = 1'b0;
        err_set   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                key_wr    = accept && key_config;
                key_start = accept && key_config;
                err_set   = accept && !key_config;
            end
            ST_KEYLOAD: begin
                key_wr    = accept && key_config;
                key_abort = accept && !key_config;
                err_set   = accept && !key_config;
            end
            ST_READY: begin
                key_wr    = accept && key_config;
                key_start = accept && key_config;
                issue     = accept && !key_config;
            end
            ST_BUSY: begin
                // Any offer while busy is an overrun, even on the done cycle.
                err_set = in_valid || wd_expired;
            end
            default: ;
        endcase
        rdy_d = (state_d != ST_BUSY);
    end

    // ---------------- registered outputs and watchdog ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q   <= 1'b1;
            error_q <= 1'b0;
            start_q <= 1'b0;
            cdata_q <= '0;
            wd_q    <= '0;
        end else begin
            rdy_q   <= rdy_d;
            error_q <= error_q | err_set;
            start_q <= issue;
            if (issue) cdata_q <= data_in;
            if (issue)                     wd_q <= '0;
            else if (state_q == ST_BUSY)   wd_q <= wd_q + WD_W'(1);
        end
    end

    dsec_key_regs u_key_regs (
        .clk         (clk),
        .rst         (rst),
        .wr_i        (key_wr),
        .start_i     (key_start),
        .abort_i     (key_abort),
        .data_i      (data_in),
        .keys_o      (keys),
        .keys_valid_o(keys_valid),
        .last_o      (key_last)
    );

    assign key1       = keys[0];
    assign key2       = keys[1];
    assign key3       = keys[2];
    assign rdy        = rdy_q;
    assign error      = error_q;
    assign core_start = start_q;
    assign core_data  = cdata_q;

endmodule

// File: tb/tb_dsec_in_ctrl.sv
module tb_dsec_in_ctrl;

    localparam int TO = 64;

    localparam logic [63:0] KA1 = 64'h9474B8E8C73BCA7D;
    localparam logic [63:0] KA2 = 64'h8DA744E0C94E5E17;
    localparam logic [63:0] KA3 = 64'h0CDB25E3BA3C6D79;
    localparam logic [63:0] KB1 = 64'h0CDB25E3BA3C6D79;
    localparam logic [63:0] KB2 = 64'h4784C4BA5006081F;
    localparam logic [63:0] KB3 = 64'h1CF1FC126F2EF842;
    localparam logic [63:0] DA  = 64'h9474B8E8C73BCA7D;
    localparam logic [63:0] DB  = 64'h1CF1FC126F2EF842;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data_in;
    logic        key_config, in_valid, core_done;
    logic        rdy, error, keys_valid, core_start;
    logic [63:0] key1, key2, key3, core_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: key set tracked as a fill count (0 = no partial set),
    // core activity as a busy flag plus elapsed-cycle count.
    logic [63:0] m_keys [3];
    bit          m_kv, m_busy, m_err, m_rdy, m_start;
    int          m_cnt, m_age;
    logic [63:0] m_cdata;

    dsec_in_ctrl #(.DONE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .key_config(key_config),
        .in_valid(in_valid), .rdy(rdy), .error(error), .key1(key1),
        .key2(key2), .key3(key3), .keys_valid(keys_valid),
        .core_data(core_data), .core_start(core_start), .core_done(core_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "timeout");
    end

    task automatic model_step(input bit v, input bit kc, input logic [63:0] d,
                              input bit done, input bit r);
        if (r) begin
            for (int i = 0; i < 3; i++) m_keys[i] = '0;
            m_kv = 0; m_busy = 0; m_err = 0; m_rdy = 1; m_start = 0;
            m_cnt = 0; m_age = 0; m_cdata = '0;
            return;
        end
        m_start = 0;
        if (m_busy) begin
            if (v) m_err = 1;
            if (done) begin
                m_busy = 0; m_rdy = 1;
            end else if (m_age == TO - 1) begin
                m_err = 1; m_busy = 0; m_rdy = 1;
            end else begin
                m_age++;
            end
        end else if (v) begin
            if (kc) begin
                if (m_cnt == 0) m_kv = 0;
                m_keys[m_cnt] = d;
                m_cnt++;
                if (m_cnt == 3) begin m_kv = 1; m_cnt = 0; end
            end else if (m_kv && m_cnt == 0) begin
                m_cdata = d; m_start = 1; m_busy = 1; m_rdy = 0; m_age = 0;
            end else begin
                m_err = 1; m_cnt = 0;
            end
        end
    endtask

    // Drive one cycle of inputs (from a falling edge), let the rising edge
    // happen, update the model, and return at the next falling edge.
    task automatic tick(input bit v, input bit kc, input logic [63:0] d,
                        input bit done, input bit r);
        in_valid = v; key_config = kc; data_in = d; core_done = done; rst = r;
        @(posedge clk);
        model_step(v, kc, d, done, r);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, '0, 0, 0);
    endtask

    task automatic load(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        tick(1, 1, a, 0, 0);
        tick(1, 1, b, 0, 0);
        tick(1, 1, c, 0, 0);
    endtask

    task automatic test_reset();
        tick(0, 0, '0, 0, 1);
        n_checks++; if (rdy !== 1'b1)        begin n_fail++; $display("FAIL reset_rdy: got %b want 1", rdy); end
        n_checks++; if (error !== 1'b0)      begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
        n_checks++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL reset_kv: got %b want 0", keys_valid); end
        n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", core_start); end
        n_checks++; if ({key1, key2, key3, core_data} !== '0)
            begin n_fail++; $display("FAIL reset_regs: got %h %h %h %h want 0", key1, key2, key3, core_data); end
    endtask

    task automatic test_key_load();
        tick(1, 1, KA1, 0, 0);
        tick(0, 1, '0, 0, 0);
        tick(1, 1, KA2, 0, 0);
        n_checks++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL load_kv_partial: got %b want 0", keys_valid); end
        tick(1, 1, KA3, 0, 0);
        n_checks++; if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL load_kv: got %b want 1", keys_valid); end
        n_checks++; if (key1 !== KA1) begin n_fail++; $display("FAIL load_key1: got %h want %h", key1, KA1); end
        n_checks++; if (key2 !== KA2) begin n_fail++; $display("FAIL load_key2: got %h want %h", key2, KA2); end
        n_checks++; if (key3 !== KA3) begin n_fail++; $display("FAIL load_key3: got %h want %h", key3, KA3); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL load_error: got %b want 0", error); end
    endtask

    task automatic test_data_issue();
        tick(1, 0, DA, 0, 0);
        n_checks++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL issue_start: got %b want 1", core_start); end
        n_checks++; if (core_data !== DA)    begin n_fail++; $display("FAIL issue_data: got %h want %h", core_data, DA); end
        n_checks++; if (rdy !== 1'b0)        begin n_fail++; $display("FAIL issue_rdy: got %b want 0", rdy); end
        idle(1);
        n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL issue_pulse: got %b want 0", core_start); end
        idle(3);
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL issue_rdy_busy: got %b want 0", rdy); end
        tick(0, 0, '0, 1, 0);
        n_checks++; if (rdy !== 1'b1)   begin n_fail++; $display("FAIL done_rdy: got %b want 1", rdy); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL done_error: got %b want 0", error); end
    endtask

    task automatic test_overrun();
        tick(1, 0, DB, 0, 0);
        tick(1, 0, 64'h0, 0, 0);
        n_checks++; if (core_data !== DB)    begin n_fail++; $display("FAIL overrun_data: got %h want %h", core_data, DB); end
        n_checks++; if (error !== 1'b1)      begin n_fail++; $display("FAIL overrun_error: got %b want 1", error); end
        n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL overrun_start: got %b want 0", core_start); end
        tick(0, 0, '0, 1, 0);
        idle(2);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", error); end
        n_checks++; if (rdy !== 1'b1)   begin n_fail++; $display("FAIL overrun_rdy: got %b want 1", rdy); end
    endtask

    task automatic test_proto_errors();
        tick(0, 0, '0, 0, 1);
        tick(1, 0, DA, 0, 0);
        n_checks++; if (error !== 1'b1)      begin n_fail++; $display("FAIL idle_data_error: got %b want 1", error); end
        n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL idle_data_start: got %b want 0", core_start); end
        tick(0, 0, '0, 0, 1);
        tick(1, 1, KA1, 0, 0);
        tick(1, 1, KA2, 0, 0);
        tick(1, 0, DA, 0, 0);
        n_checks++; if (error !== 1'b1)      begin n_fail++; $display("FAIL partial_error: got %b want 1", error); end
        n_checks++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL partial_kv: got %b want 0", keys_valid); end
        // Back in IDLE: another data word must still be dropped.
        tick(1, 0, DA, 0, 0);
        n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL partial_idle: got %b want 0", core_start); end
        // A fresh load from IDLE starts at key1 again.
        load(KB1, KB2, KB3);
        n_checks++; if (key1 !== KB1 || keys_valid !== 1'b1)
            begin n_fail++; $display("FAIL partial_reload: got %h/%b want %h/1", key1, keys_valid, KB1); end
    endtask

    task automatic test_reload();
        tick(0, 0, '0, 0, 1);
        load(KA1, KA2, KA3);
        tick(1, 0, DA, 0, 0);
        tick(0, 0, '0, 1, 0);
        tick(1, 1, KB1, 0, 0);
        n_checks++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL reload_kv_drop: got %b want 0", keys_valid); end
        tick(1, 1, KB2, 0, 0);
        tick(1, 1, KB3, 0, 0);
        n_checks++; if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL reload_kv: got %b want 1", keys_valid); end
        n_checks++; if ({key1, key2, key3} !== {KB1, KB2, KB3})
            begin n_fail++; $display("FAIL reload_keys: got %h %h %h", key1, key2, key3); end
        tick(1, 0, 64'h0, 0, 0);
        n_checks++; if (core_start !== 1'b1 || core_data !== 64'h0)
            begin n_fail++; $display("FAIL zero_word: got start=%b data=%h want 1/0", core_start, core_data); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reload_error: got %b want 0", error); end
        tick(0, 0, '0, 1, 0);
    endtask

    task automatic test_watchdog();
        tick(0, 0, '0, 0, 1);
        load(KA1, KA2, KA3);
        tick(1, 0, DA, 0, 0);
        idle(TO - 1);
        n_checks++; if (error !== 1'b0 || rdy !== 1'b0)
            begin n_fail++; $display("FAIL wd_early: got err=%b rdy=%b want 0/0", error, rdy); end
        idle(1);
        n_checks++; if (error !== 1'b1 || rdy !== 1'b1)
            begin n_fail++; $display("FAIL wd_fire: got err=%b rdy=%b want 1/1", error, rdy); end
        tick(1, 0, DB, 0, 0);
        n_checks++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL wd_ready: got %b want 1", core_start); end
        idle(3);
        tick(0, 0, '0, 0, 1);
        n_checks++; if ({rdy, error, keys_valid, core_start} !== 4'b1000)
            begin n_fail++; $display("FAIL busy_rst_ctl: got %b want 1000", {rdy, error, keys_valid, core_start}); end
        n_checks++; if ({key1, key2, key3, core_data} !== '0)
            begin n_fail++; $display("FAIL busy_rst_regs: got %h %h %h %h want 0", key1, key2, key3, core_data); end
    endtask

    task automatic test_random();
        bit v, kc, dn, r;
        logic [63:0] d;
        tick(0, 0, '0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 149) == 0);
            v  = m_busy ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
            kc = (m_cnt > 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4);
            // Alternate phases with a responsive core and a stalled one.
            dn = ((i / 400) % 2 == 0) ? ($urandom_range(0, 5) == 0) : 1'b0;
            if (!m_busy && $urandom_range(0, 19) == 0) dn = 1'b1;
            d  = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) d = '0;
            tick(v, kc, d, dn, r);
            n_checks++; if (rdy !== m_rdy)        begin n_fail++; $display("FAIL rnd_rdy @%0d: got %b want %b", i, rdy, m_rdy); end
            n_checks++; if (error !== m_err)      begin n_fail++; $display("FAIL rnd_error @%0d: got %b want %b", i, error, m_err); end
            n_checks++; if (keys_valid !== m_kv)  begin n_fail++; $display("FAIL rnd_kv @%0d: got %b want %b", i, keys_valid, m_kv); end
            n_checks++; if (core_start !== m_start) begin n_fail++; $display("FAIL rnd_start @%0d: got %b want %b", i, core_start, m_start); end
            n_checks++; if (core_data !== m_cdata) begin n_fail++; $display("FAIL rnd_data @%0d: got %h want %h", i, core_data, m_cdata); end
            n_checks++; if (key1 !== m_keys[0])   begin n_fail++; $display("FAIL rnd_key1 @%0d: got %h want %h", i, key1, m_keys[0]); end
            n_checks++; if (key2 !== m_keys[1])   begin n_fail++; $display("FAIL rnd_key2 @%0d: got %h want %h", i, key2, m_keys[1]); end
            n_checks++; if (key3 !== m_keys[2])   begin n_fail++; $display("FAIL rnd_key3 @%0d: got %h want %h", i, key3, m_keys[2]); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; key_config = 1'b0; core_done = 1'b0; data_in = '0;
        @(negedge clk);
        test_reset();
        test_key_load();
        test_data_issue();
        test_overrun();
        test_proto_errors();
        test_reload();
        test_watchdog();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
